ysyx_22041752_mem_rd_arbiter: RTL

//  Two-requester read arbiter/sequencer for the single external memory read port.

---
 rtl/ysyx_22041752_mem_rd_arbiter_pkg.sv | 35 +++
 rtl/ysyx_22041752_mem_rd_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_mem_rd_arbiter_pkg.sv
// Shared definitions for the I-cache / D-cache memory read arbiter:
// FSM state encoding, requester IDs, default widths and the tie-break helper.
package ysyx_22041752_mem_rd_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    // With rr_en set, a tie goes to whoever did not own the previous burst.
    function automatic logic pick_owner(
        input logic ic_req,
        input logic dc_req,
        input logic last_owner,
        input logic rr_en
    );
        logic win;
        win = OWNER_IC;
        if (ic_req && dc_req) begin
            win = rr_en ? ~last_owner : OWNER_DC;
        end else if (dc_req) begin
            win = OWNER_DC;
        end
        return win;
    endfunction

endpackage

// File: rtl/ysyx_22041752_mem_rd_arbiter.sv
// Two-requester (IC/DC) read arbiter holding the bus for a whole burst.
// Define YSYX_22041752_ARB_RR_EN for round-robin tie-break; default is DC-over-IC.
module ysyx_22041752_mem_rd_arbiter
    import ysyx_22041752_mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [LEN_W-1:0]  ic_len,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic              ic_rlast,

    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LEN_W-1:0]  dc_len,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic              dc_rlast,

    output logic [DATA_W-1:0] rdata,

    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [LEN_W-1:0]  m_arlen,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rlast,

    output logic              len_err,
    output logic [1:0]        dbg_state_o
);

`ifdef YSYX_22041752_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    // Handshakes: an address is accepted when m_arvalid && m_arready; a beat is
    // accepted when m_rvalid && m_rready. Requesters hold *_req until *_gnt.
    arb_state_e         state_q;
    logic               owner_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W:0]     cnt_q;
    logic               arvalid_q;
    logic               rready_q;
    logic               len_err_q;

    logic               win_d;
    logic               ar_hs;
    logic               beat;
    logic               cnt_at_len;

    assign win_d      = pick_owner(ic_req, dc_req, owner_q, RR_EN);
    assign ar_hs      = arvalid_q && m_arready;
    assign beat       = rready_q && m_rvalid;
    assign cnt_at_len = (cnt_q == {1'b0, len_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_IC;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ic_req || dc_req) begin
                        owner_q   <= win_d;
                        addr_q    <= (win_d == OWNER_DC) ? dc_addr : ic_addr;
                        len_q     <= (win_d == OWNER_DC) ? dc_len : ic_len;
                        arvalid_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        // Early rlast, or the final counted beat without rlast.
                        if (m_rlast != cnt_at_len) begin
                            len_err_q <= 1'b1;
                        end
                        if (m_rlast) begin
                            rready_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_arvalid   = arvalid_q;
    assign m_araddr    = addr_q;
    assign m_arlen     = len_q;
    assign m_rready    = rready_q;
    assign rdata       = m_rdata;
    assign len_err     = len_err_q;
    assign dbg_state_o = state_q;

    assign ic_gnt    = ar_hs && (owner_q == OWNER_IC);
    assign dc_gnt    = ar_hs && (owner_q == OWNER_DC);
    assign ic_rvalid = beat && (owner_q == OWNER_IC);
    assign dc_rvalid = beat && (owner_q == OWNER_DC);
    assign ic_rlast  = beat && m_rlast && (owner_q == OWNER_IC);
    assign dc_rlast  = beat && m_rlast && (owner_q == OWNER_DC);

endmodule
